imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: ADDR_W, 8, instruction-memory address width; depth is 2^ADDR_W words of 16 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  begin a load; sampled only in IDLE.
REQ-005 len  input  ADDR_W+1  word count to load, 0..2^ADDR_W; latched when start is accepted.
REQ-006 abort  input  1  synchronous cancel of an in-progress load.
REQ-007 in_data  input  8  byte stream from host.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  loader accepts a byte; transfer when in_valid and in_ready are both 1 on a clock edge.
REQ-010 wr_en  output  1  one-cycle write strobe toward the instruction-memory write port.
REQ-011 wr_addr  output  ADDR_W  write address.
REQ-012 wr_data  output  16  write data.
REQ-013 busy  output  1  load in progress; CPU fetch held while 1.
REQ-014 done  output  1  one-cycle pulse at load completion.
REQ-015 error  output  1  checksum mismatch flag (see Configuration).

Function
REQ-016 The FSM SHALL have states IDLE, LO, HI, CHK_LO, CHK_HI, FIN; in_ready=1 only in LO, HI, CHK_LO, CHK_HI.
REQ-017 IDLE: start=1 with len>0 SHALL latch len, clear address counter to 0 and word counter to 0, enter LO; busy=1 from next cycle.
REQ-018 IDLE: start=1 with len=0 SHALL produce done=1 on the next cycle, no wr_en, FSM stays IDLE, busy stays 0.
REQ-019 LO: an accepted byte SHALL be stored as the low byte; go HI.
REQ-020 HI: an accepted byte SHALL be the high byte; on the following cycle wr_en=1, wr_addr=address counter, wr_data={high,low}; address and word counters increment.
REQ-021 After HI, if word counter+1 equals len go to CHK_LO (macro defined) or FIN (macro undefined), else go LO.
REQ-022 Write strobe SHALL overlap the next LO cycle; sustained throughput is one word per two accepted bytes, no bubbles.
REQ-023 Address counter SHALL be ADDR_W bits; len=2^ADDR_W writes addresses 0..2^ADDR_W-1 exactly once, counter wraps to 0, load terminates by word count.
REQ-024 FIN: done=1 for exactly one cycle, busy=0 on the same cycle, return to IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 abort=1 in any non-IDLE state SHALL return to IDLE next cycle, no done, no write of a partially received word; a write already scheduled from a completed HI byte still issues.
REQ-027 abort and start in the same IDLE cycle: start wins; abort in IDLE has no effect.
REQ-028 wr_en, done SHALL be registered outputs; wr_addr/wr_data hold last written values when wr_en=0.

Reset
REQ-029 rst_n=0 SHALL immediately force IDLE, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error=0, counters=0, regardless of clock.
REQ-030 Reset mid-load SHALL discard the load; no done after release.

Configuration
REQ-031 Macro IMEM_LOADER_CHECKSUM_EN defined: a 16-bit running sum (mod 2^16) of all written words is kept; after the last word, two trailer bytes (low, high) are accepted in CHK_LO/CHK_HI; error=1 if trailer differs from sum, else 0; error is set on the FIN cycle, held until the next accepted start clears it; done pulses either way.
REQ-032 Macro undefined: no trailer states reachable, HI goes directly to FIN, error port present and tied 0.

Verification
REQ-033 len=2, bytes 34 12 78 56, valid every cycle -> wr_en at addr 0 data 0x1234, addr 1 data 0x5678, done one pulse, busy falls with done.
REQ-034 len=0 with start -> done pulse next cycle, no wr_en, busy never 1.
REQ-035 len=256, bytes with in_valid toggling 1/0 -> 256 writes addresses 0..255 in order, no repeat at 0, single done.
REQ-036 len=3, abort after 3 bytes -> one write (addr 0), no second write, no done, FSM IDLE; rst_n low mid-load -> all outputs 0 immediately.
REQ-037 IMEM_LOADER_CHECKSUM_EN, len=2 words 0x1234, 0x5678, trailer 0x68AC -> error=0; trailer 0x68AD -> error=1, done pulses, error cleared on next start.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-stream loader that assembles little-endian 16-bit words and writes them into instruction memory.
// Optional trailer checksum check is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        CHK_LO,
        CHK_HI,
        FIN
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
    logic [7:0]          low_q, low_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         wr_data_q, wr_data_d;
    logic                done_q, done_d;
    logic [ADDR_W:0]     word_cnt_inc;
    logic [15:0]         word_in;
    logic                accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [15:0]         sum_q, sum_d;
    logic                error_q, error_d;
`endif

    assign in_ready     = (state_q == LO) || (state_q == HI) ||
                          (state_q == CHK_LO) || (state_q == CHK_HI);
    assign busy         = in_ready;
    assign accept       = in_valid && in_ready;
    assign word_cnt_inc = word_cnt_q + 1'b1;
    assign word_in      = {in_data, low_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        addr_d     = addr_q;
        word_cnt_d = word_cnt_q;
        low_d      = low_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        error_d    = error_q;
`endif
        case (state_q)
            IDLE: begin
                // abort is ignored here, so a simultaneous start always wins
                if (start) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    error_d = 1'b0;
`endif
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d      = len;
                        addr_d     = '0;
                        word_cnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_d      = '0;
`endif
                        state_d    = LO;
                    end
                end
            end
            LO: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    low_d   = in_data;
                    state_d = HI;
                end
            end
            HI: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = addr_q;
                    wr_data_d  = word_in;
                    addr_d     = addr_q + 1'b1;
                    word_cnt_d = word_cnt_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + word_in;
`endif
                    // Termination is by word count; the address counter simply wraps.
                    if (word_cnt_inc == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = CHK_LO;
`else
                        state_d = FIN;
                        done_d  = 1'b1;
`endif
                    end else begin
                        state_d = LO;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK_LO: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    low_d   = in_data;
                    state_d = CHK_HI;
                end
            end
            CHK_HI: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (accept) begin
                    error_d = (word_in != sum_q);
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end
`endif
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            len_q      <= '0;
            addr_q     <= '0;
            word_cnt_q <= '0;
            low_q      <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            word_cnt_q <= word_cnt_d;
            low_q      <= low_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            error_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader: expected writes, done pulses and
// checksum verdicts are derived from the word list sent, compared against a monitor log.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W:0]   len;
    logic              abort;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic              busy;
    logic              done;
    logic              error;

    int nChecks = 0;
    int nFails  = 0;

    logic [ADDR_W-1:0] obsAddr[$];
    logic [15:0]       obsData[$];
    logic [15:0]       words[$];
    int                doneCount;
    int                busyDoneOverlap;
    logic              errAtDone;
    logic              busySeen;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
        .abort    (abort),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: log every write strobe and done pulse at the falling edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            obsAddr.push_back(wr_addr);
            obsData.push_back(wr_data);
        end
        if (done === 1'b1) begin
            doneCount++;
            errAtDone = error;
            if (busy !== 1'b0) busyDoneOverlap++;
        end
        if (busy === 1'b1) busySeen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic clearLog();
        obsAddr.delete();
        obsData.delete();
        doneCount       = 0;
        busyDoneOverlap = 0;
        errAtDone       = 1'b0;
        busySeen        = 1'b0;
    endtask

    // Present one byte and hold it until the loader takes it (bounded wait)
    task automatic sendByte(input logic [7:0] b);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 100) checkOutput("ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Run one load of the words queue. gapMode: 0 none, 1 one idle cycle, 2 random idles.
    // abortAfter < 0 means no abort; otherwise abort after that many bytes.
    task automatic applyStimulus(input int n, input int gapMode, input int abortAfter,
                                 input bit holdStart, input bit badTrailer);
        int          nBytes;
        int          expWords;
        bit          aborted;
        logic [15:0] sum;
        logic [15:0] trailer;
        logic [7:0]  b;
        clearLog();
        sum = 16'h0;
        for (int i = 0; i < n; i++) sum = sum + words[i];
        trailer = badTrailer ? sum + 16'h1 : sum;
        nBytes  = 2 * n;
`ifdef IMEM_LOADER_CHECKSUM_EN
        nBytes  = nBytes + 2;
`endif
        aborted = 1'b0;
        start = 1'b1;
        len   = (ADDR_W+1)'(n);
        @(posedge clk); #1;
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("err_cleared", 32'(error), 32'd0);
        start = holdStart;
        len   = (ADDR_W+1)'($urandom_range(0, 2 * DEPTH - 1));
        for (int k = 0; k < nBytes; k++) begin
            if (abortAfter >= 0 && k == abortAfter) begin
                aborted = 1'b1;
                break;
            end
            if (k < 2 * n) b = k[0] ? words[k / 2][15:8] : words[k / 2][7:0];
            else           b = (k == 2 * n) ? trailer[7:0] : trailer[15:8];
            if (k == nBytes - 1) start = 1'b0;
            if (gapMode == 1 && k > 0) begin
                @(posedge clk); #1;
            end else if (gapMode == 2) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
            sendByte(b);
        end
        start = 1'b0;
        if (aborted) begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            checkOutput("abort_idle", {30'd0, busy, in_ready}, 32'd0);
        end
        repeat (4) begin
            @(posedge clk); #1;
        end
        expWords = aborted ? abortAfter / 2 : n;
        checkOutput("wr_count", 32'(obsAddr.size()), 32'(expWords));
        for (int i = 0; i < expWords && i < obsAddr.size(); i++) begin
            checkOutput("wr_addr", 32'(obsAddr[i]), 32'(i % DEPTH));
            checkOutput("wr_data", 32'(obsData[i]), 32'(words[i]));
        end
        checkOutput("done_count", 32'(doneCount), aborted ? 32'd0 : 32'd1);
        checkOutput("busy_with_done", 32'(busyDoneOverlap), 32'd0);
        checkOutput("busy_end", 32'(busy), 32'd0);
        if (expWords > 0) begin
            checkOutput("hold_addr", 32'(wr_addr), 32'((expWords - 1) % DEPTH));
            checkOutput("hold_data", 32'(wr_data), 32'(words[expWords - 1]));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (!aborted) begin
            checkOutput("err_at_done", 32'(errAtDone), 32'(badTrailer));
            checkOutput("err_held", 32'(error), 32'(badTrailer));
        end
`else
        checkOutput("error_tied", 32'(error), 32'd0);
`endif
    endtask

    task automatic randomWords(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        len      = '0;
        abort    = 1'b0;
        in_data  = 8'h0;
        in_valid = 1'b0;
        clearLog();
        #2;
        checkOutput("reset_outputs", {22'd0, in_ready, wr_en, busy, done, error, 5'd0}, 32'd0);
        checkOutput("reset_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset_data", 32'(wr_data), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] directed two-word load");
        words.delete();
        words.push_back(16'h1234);
        words.push_back(16'h5678);
        applyStimulus(2, 0, -1, 1'b0, 1'b0);

        $display("[TB] zero-length start");
        clearLog();
        start = 1'b1;
        len   = '0;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("len0_done", 32'(done), 32'd1);
        @(posedge clk); #1;
        checkOutput("len0_done_once", 32'(done), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checkOutput("len0_no_write", 32'(obsAddr.size()), 32'd0);
        checkOutput("len0_never_busy", 32'(busySeen), 32'd0);
        checkOutput("len0_done_count", 32'(doneCount), 32'd1);

        $display("[TB] full-depth load with toggling valid");
        randomWords(DEPTH);
        applyStimulus(DEPTH, 1, -1, 1'b0, 1'b0);

        $display("[TB] abort after three bytes");
        randomWords(3);
        applyStimulus(3, 0, 3, 1'b0, 1'b0);

        $display("[TB] random loads");
        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 20);
            randomWords(n);
            applyStimulus(n, 2, -1, bit'($urandom_range(0, 1)), 1'b0);
        end

        $display("[TB] reset mid-load");
        randomWords(3);
        words[0] = 16'hA5C3;
        start = 1'b1;
        len   = 9'd3;
        @(posedge clk); #1;
        start = 1'b0;
        sendByte(words[0][7:0]);
        sendByte(words[0][15:8]);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_outputs", {22'd0, in_ready, wr_en, busy, done, error, 5'd0}, 32'd0);
        checkOutput("rst_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_data", 32'(wr_data), 32'd0);
        @(posedge clk); #1;
        clearLog();
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_no_done", 32'(doneCount), 32'd0);
        checkOutput("rst_no_write", 32'(obsAddr.size()), 32'd0);
        checkOutput("rst_idle", 32'(busy), 32'd0);

        randomWords(5);
        applyStimulus(5, 0, -1, 1'b0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] checksum trailer");
        words.delete();
        words.push_back(16'h1234);
        words.push_back(16'h5678);
        applyStimulus(2, 0, -1, 1'b0, 1'b0);
        applyStimulus(2, 0, -1, 1'b0, 1'b1);
        randomWords(4);
        applyStimulus(4, 2, -1, 1'b0, 1'b0);
        randomWords(4);
        applyStimulus(4, 2, 9, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
        $finish;
    end

endmodule
